// File: rtl/mps_op_fsm.sv
// rtl/mps_op_fsm.sv - MPS main operation sequencer (precharge, contactor, PWM, discharge, fault latch)
// Optional discharge relay sequencing is enabled by defining MPS_DISCHARGE_EN.
module mps_op_fsm #(
    parameter int PRECHG_CNT  = 1000,
    parameter int FB_TIMEOUT  = 5000,
    parameter int PWM_OFF_CNT = 100,
    parameter int DISCHG_CNT  = 2000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_op_on,
    input  logic       i_run,
    input  logic       i_ready,
    input  logic       i_op_off,
    input  logic       i_intl_clr,
    input  logic       i_intl,
    input  logic       i_dc_ok,
    input  logic       i_mc_fb,
    output logic       o_pwm_en,
    output logic [2:0] o_mc,
    output logic [2:0] o_mps_fsm_m,
    output logic [3:0] o_op_on_fsm,
    output logic [3:0] o_op_off_fsm,
    output logic [3:0] o_on_state_fail_buf
);
    localparam int MAX_A = (PRECHG_CNT > FB_TIMEOUT) ? PRECHG_CNT : FB_TIMEOUT;
    localparam int MAX_B = (PWM_OFF_CNT > DISCHG_CNT) ? PWM_OFF_CNT : DISCHG_CNT;
    localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_P) + 1;

`ifdef MPS_DISCHARGE_EN
    localparam logic DIS_BIT = 1'b1;
`else
    localparam logic DIS_BIT = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_OP_ON = 3'd1, S_READY = 3'd2,
        S_RUN = 3'd3, S_OP_OFF = 3'd4, S_FAULT = 3'd5
    } top_t;
    typedef enum logic [3:0] {
        ON_IDLE = 4'd0, ON_PRECHG = 4'd1, ON_PRECHG_WAIT = 4'd2,
        ON_MC_CLOSE = 4'd3, ON_PRECHG_OPEN = 4'd4, ON_DONE = 4'd5
    } on_step_t;
    typedef enum logic [3:0] {
        OFF_IDLE = 4'd0, OFF_PWM_OFF = 4'd1, OFF_MC_OPEN = 4'd2,
        OFF_DISCHARGE = 4'd3, OFF_DONE = 4'd4
    } off_step_t;

    top_t          state_q, state_d;
    on_step_t      on_q, on_d;
    off_step_t     off_q, off_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pwm_q, pwm_d;
    logic [2:0]    mc_q, mc_d;
    logic [3:0]    fail_q, fail_d;
    logic [4:0]    prev_q;
    logic [3:0]    fail_code;
    logic          go_fault;

    logic e_op_on, e_run, e_ready, e_op_off, e_clr;
    logic sel_off, sel_on, sel_ready, sel_run;

    assign e_op_on  = i_op_on    & ~prev_q[0];
    assign e_run    = i_run      & ~prev_q[1];
    assign e_ready  = i_ready    & ~prev_q[2];
    assign e_op_off = i_op_off   & ~prev_q[3];
    assign e_clr    = i_intl_clr & ~prev_q[4];

    // Highest-priority edge wins even when the current state then ignores it.
    assign sel_off   = e_op_off;
    assign sel_on    = e_op_on & ~e_op_off;
    assign sel_ready = e_ready & ~e_op_off & ~e_op_on;
    assign sel_run   = e_run & ~e_op_off & ~e_op_on & ~e_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            on_q    <= ON_IDLE;
            off_q   <= OFF_IDLE;
            cnt_q   <= '0;
            pwm_q   <= 1'b0;
            mc_q    <= 3'b000;
            fail_q  <= 4'd0;
            prev_q  <= 5'b0;
        end else begin
            state_q <= state_d;
            on_q    <= on_d;
            off_q   <= off_d;
            cnt_q   <= cnt_d;
            pwm_q   <= pwm_d;
            mc_q    <= mc_d;
            fail_q  <= fail_d;
            prev_q  <= {i_intl_clr, i_op_off, i_ready, i_run, i_op_on};
        end
    end

    always_comb begin
        state_d   = state_q;
        on_d      = on_q;
        off_d     = off_q;
        cnt_d     = cnt_q + CW'(1);
        pwm_d     = pwm_q;
        mc_d      = mc_q;
        fail_d    = fail_q;
        fail_code = 4'd0;
        go_fault  = 1'b0;
        case (state_q)
            S_IDLE: begin
                pwm_d = 1'b0;
                mc_d  = 3'b000;
                if (sel_on) begin
                    state_d = S_OP_ON;
                    on_d    = ON_PRECHG;
                    cnt_d   = '0;
                    mc_d    = 3'b001;
                end
            end
            S_OP_ON: begin
                case (on_q)
                    ON_PRECHG: begin
                        on_d  = ON_PRECHG_WAIT;
                        cnt_d = '0;
                    end
                    ON_PRECHG_WAIT: begin
                        if (cnt_q == CW'(PRECHG_CNT - 1)) begin
                            if (i_dc_ok) begin
                                on_d  = ON_MC_CLOSE;
                                cnt_d = '0;
                                mc_d  = 3'b011;
                            end else begin
                                fail_code = 4'd1;
                            end
                        end
                    end
                    ON_MC_CLOSE: begin
                        if (i_mc_fb) begin
                            on_d = ON_PRECHG_OPEN;
                            mc_d = 3'b010;
                        end else if (cnt_q == CW'(FB_TIMEOUT - 1)) begin
                            fail_code = 4'd2;
                        end
                    end
                    ON_PRECHG_OPEN: on_d = ON_DONE;
                    ON_DONE: begin
                        state_d = S_READY;
                        on_d    = ON_IDLE;
                    end
                    default: go_fault = 1'b1;
                endcase
            end
            S_READY, S_RUN: begin
                mc_d  = 3'b010;
                pwm_d = (state_q == S_RUN);
                if (!i_mc_fb) begin
                    fail_code = 4'd4;
                end else if (sel_off) begin
                    state_d = S_OP_OFF;
                    off_d   = OFF_PWM_OFF;
                    cnt_d   = '0;
                    pwm_d   = 1'b0;
                end else if (sel_run && state_q == S_READY) begin
                    state_d = S_RUN;
                    pwm_d   = 1'b1;
                end else if (sel_ready && state_q == S_RUN) begin
                    state_d = S_READY;
                    pwm_d   = 1'b0;
                end
            end
            S_OP_OFF: begin
                pwm_d = 1'b0;
                case (off_q)
                    OFF_PWM_OFF: begin
                        if (cnt_q == CW'(PWM_OFF_CNT - 1)) begin
                            off_d = OFF_MC_OPEN;
                            cnt_d = '0;
                            mc_d  = 3'b000;
                        end
                    end
                    OFF_MC_OPEN: begin
                        if (!i_mc_fb) begin
`ifdef MPS_DISCHARGE_EN
                            off_d = OFF_DISCHARGE;
                            cnt_d = '0;
                            mc_d  = 3'b100;
`else
                            off_d = OFF_DONE;
`endif
                        end else if (cnt_q == CW'(FB_TIMEOUT - 1)) begin
                            fail_code = 4'd3;
                        end
                    end
`ifdef MPS_DISCHARGE_EN
                    OFF_DISCHARGE: begin
                        if (cnt_q == CW'(DISCHG_CNT - 1)) begin
                            off_d = OFF_DONE;
                            mc_d  = 3'b000;
                        end
                    end
`endif
                    OFF_DONE: begin
                        state_d = S_IDLE;
                        off_d   = OFF_IDLE;
                    end
                    default: go_fault = 1'b1;
                endcase
            end
            S_FAULT: begin
                if (e_clr && !i_intl) begin
                    state_d = S_IDLE;
                    fail_d  = 4'd0;
                    mc_d    = 3'b000;
                end
            end
            default: go_fault = 1'b1;
        endcase

        if (state_q != S_FAULT && (i_intl || fail_code != 4'd0 || go_fault)) begin
            state_d = S_FAULT;
            on_d    = ON_IDLE;
            off_d   = OFF_IDLE;
            cnt_d   = '0;
            pwm_d   = 1'b0;
            mc_d    = {DIS_BIT, 2'b00};
            if (fail_q == 4'd0)
                fail_d = i_intl ? 4'd8 : fail_code;
        end
    end

    assign o_pwm_en            = pwm_q;
    assign o_mc                = mc_q;
    assign o_mps_fsm_m         = state_q;
    assign o_op_on_fsm         = on_q;
    assign o_op_off_fsm        = off_q;
    assign o_on_state_fail_buf = fail_q;
endmodule

// File: tb/tb_mps_op_fsm.sv
// tb/tb_mps_op_fsm.sv - directed self-checking bench for mps_op_fsm
module tb_mps_op_fsm;
    logic       clk = 1'b0;
    logic       rst, op_on, run, ready, op_off, intl_clr, intl, dc_ok, mc_fb;
    logic       pwm_en;
    logic [2:0] mc, top;
    logic [3:0] on_fsm, off_fsm, fail_buf;
    int         checks = 0;
    int         failures = 0;

`ifdef MPS_DISCHARGE_EN
    localparam logic [2:0] MC_FLT = 3'b100;
`else
    localparam logic [2:0] MC_FLT = 3'b000;
`endif

    mps_op_fsm #(.PRECHG_CNT(10), .FB_TIMEOUT(20), .PWM_OFF_CNT(100), .DISCHG_CNT(2000)) dut (
        .i_clk(clk), .i_rst(rst), .i_op_on(op_on), .i_run(run), .i_ready(ready),
        .i_op_off(op_off), .i_intl_clr(intl_clr), .i_intl(intl), .i_dc_ok(dc_ok),
        .i_mc_fb(mc_fb), .o_pwm_en(pwm_en), .o_mc(mc), .o_mps_fsm_m(top),
        .o_op_on_fsm(on_fsm), .o_op_off_fsm(off_fsm), .o_on_state_fail_buf(fail_buf)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] e_top, input logic [2:0] e_mc,
                           input logic e_pwm, input logic [3:0] e_fail);
        chk({tag, ".top"}, {5'd0, top}, {5'd0, e_top});
        chk({tag, ".mc"}, {5'd0, mc}, {5'd0, e_mc});
        chk({tag, ".pwm"}, {7'd0, pwm_en}, {7'd0, e_pwm});
        chk({tag, ".fail"}, {4'd0, fail_buf}, {4'd0, e_fail});
    endtask

    // Nominal power-up from IDLE to READY with feedback already closed.
    task automatic bring_up();
        op_on = 1'b1; dc_ok = 1'b1; mc_fb = 1'b1;
        tick(1); op_on = 1'b0;
        tick(12);
        tick(2);
    endtask

    task automatic clear_fault();
        intl_clr = 1'b1; tick(1);
        intl_clr = 1'b0; tick(1);
    endtask

    initial begin
        rst = 1'b1; op_on = 0; run = 0; ready = 0; op_off = 0;
        intl_clr = 0; intl = 0; dc_ok = 0; mc_fb = 0;
        tick(2);
        chk_all("reset", 3'd0, 3'b000, 1'b0, 4'd0);
        chk("reset.on", {4'd0, on_fsm}, 8'd0);
        chk("reset.off", {4'd0, off_fsm}, 8'd0);
        rst = 1'b0;
        tick(1);

        op_on = 1'b1; op_off = 1'b1; tick(1);
        chk("simul.top", {5'd0, top}, 8'd0);
        chk("simul.on", {4'd0, on_fsm}, 8'd0);
        op_on = 1'b0; op_off = 1'b0; tick(1);

        op_on = 1'b1; dc_ok = 1'b1; tick(1);
        chk("nom.step1", {4'd0, on_fsm}, 8'd1);
        chk_all("nom.prechg", 3'd1, 3'b001, 1'b0, 4'd0);
        tick(1);
        chk("nom.step2", {4'd0, on_fsm}, 8'd2);
        tick(9);
        chk("nom.step2_last", {4'd0, on_fsm}, 8'd2);
        chk("nom.held_level", {5'd0, top}, 8'd1);
        op_on = 1'b0;
        tick(1);
        chk("nom.step3", {4'd0, on_fsm}, 8'd3);
        chk("nom.mc_close", {5'd0, mc}, 8'b011);
        tick(2);
        chk("nom.wait_fb", {4'd0, on_fsm}, 8'd3);
        mc_fb = 1'b1; tick(1);
        chk("nom.step4", {4'd0, on_fsm}, 8'd4);
        chk("nom.pre_open", {5'd0, mc}, 8'b010);
        tick(1);
        chk("nom.step5", {4'd0, on_fsm}, 8'd5);
        tick(1);
        chk_all("nom.ready", 3'd2, 3'b010, 1'b0, 4'd0);
        chk("nom.step0", {4'd0, on_fsm}, 8'd0);

        run = 1'b1; tick(1); run = 1'b0;
        chk_all("run", 3'd3, 3'b010, 1'b1, 4'd0);
        ready = 1'b1; tick(1); ready = 1'b0;
        chk_all("ready_cmd", 3'd2, 3'b010, 1'b0, 4'd0);
        run = 1'b1; tick(1); run = 1'b0;
        chk("run2", {5'd0, top}, 8'd3);

        op_off = 1'b1; tick(1); op_off = 1'b0;
        chk_all("off.pwm_off", 3'd4, 3'b010, 1'b0, 4'd0);
        chk("off.step1", {4'd0, off_fsm}, 8'd1);
        tick(99);
        chk("off.step1_last", {4'd0, off_fsm}, 8'd1);
        chk("off.mc_held", {5'd0, mc}, 8'b010);
        tick(1);
        chk("off.step2", {4'd0, off_fsm}, 8'd2);
        chk("off.mc_open", {5'd0, mc}, 8'b000);
        tick(2);
        chk("off.wait_fb", {4'd0, off_fsm}, 8'd2);
        mc_fb = 1'b0; tick(1);
`ifdef MPS_DISCHARGE_EN
        chk("off.step3", {4'd0, off_fsm}, 8'd3);
        chk("off.dis_on", {5'd0, mc}, 8'b100);
        tick(1999);
        chk("off.dis_last", {5'd0, mc}, 8'b100);
        tick(1);
`endif
        chk("off.step4", {4'd0, off_fsm}, 8'd4);
        chk("off.done_mc", {5'd0, mc}, 8'b000);
        tick(1);
        chk_all("off.idle", 3'd0, 3'b000, 1'b0, 4'd0);
        chk("off.step0", {4'd0, off_fsm}, 8'd0);

        op_on = 1'b1; dc_ok = 1'b0; tick(1); op_on = 1'b0;
        tick(10);
        chk("pf.wait_last", {4'd0, on_fsm}, 8'd2);
        tick(1);
        chk_all("pf.fault", 3'd5, MC_FLT, 1'b0, 4'd1);
        chk("pf.on_step", {4'd0, on_fsm}, 8'd0);
        intl = 1'b1; tick(1); intl = 1'b0;
        chk("pf.no_overwrite", {4'd0, fail_buf}, 8'd1);
        clear_fault();
        chk_all("pf.cleared", 3'd0, 3'b000, 1'b0, 4'd0);

        op_on = 1'b1; dc_ok = 1'b1; mc_fb = 1'b0; tick(1); op_on = 1'b0;
        tick(11);
        chk("to.entry", {4'd0, on_fsm}, 8'd3);
        tick(19);
        chk("to.before", {5'd0, top}, 8'd1);
        tick(1);
        chk_all("to.fault", 3'd5, MC_FLT, 1'b0, 4'd2);
        clear_fault();

        bring_up();
        chk("intl.ready", {5'd0, top}, 8'd2);
        run = 1'b1; tick(1); run = 1'b0;
        intl = 1'b1; tick(1);
        chk_all("intl.fault", 3'd5, MC_FLT, 1'b0, 4'd8);
        intl_clr = 1'b1; tick(1); intl_clr = 1'b0;
        chk_all("intl.clr_blocked", 3'd5, MC_FLT, 1'b0, 4'd8);
        tick(1);
        intl = 1'b0; tick(1);
        chk("intl.still_fault", {5'd0, top}, 8'd5);
        clear_fault();
        chk_all("intl.cleared", 3'd0, 3'b000, 1'b0, 4'd0);

        bring_up();
        mc_fb = 1'b0; tick(1);
        chk_all("fb_loss", 3'd5, MC_FLT, 1'b0, 4'd4);
        clear_fault();

        op_on = 1'b1; mc_fb = 1'b1; tick(2); op_on = 1'b0;
        rst = 1'b1; tick(1); rst = 1'b0;
        chk_all("midrst", 3'd0, 3'b000, 1'b0, 4'd0);
        chk("midrst.on", {4'd0, on_fsm}, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mps_op_fsm.md
# mps_op_fsm

Main operation sequencer for the MPS. It consumes the level command bits written by software through the MPS System AXI4-Lite register block (op_on, run, ready, op_off, interlock clear) and drives the precharge relay, main contactor, discharge relay and PWM enable. It reports its top-level state, sub-sequence steps, latched failure code and relay outputs back into that block's read-only status registers.

## Interface
- PRECHG_CNT, 1000: precharge dwell in clock cycles before the DC-link check; must be ≥1.
- FB_TIMEOUT, 5000: maximum cycles to wait for main-contactor auxiliary feedback; must be ≥1.
- PWM_OFF_CNT, 100: cycles PWM is held off before the contactor opens; must be ≥1.
- DISCHG_CNT, 2000: discharge relay on-time in cycles; must be ≥1.
- Counter width is $clog2 of the largest parameter + 1.

Ports:
- i_clk  in  1  system clock, the same clock as S_AXI_ACLK.
- i_rst  in  1  synchronous, active-high reset.
- i_op_on  in  1  op-on command level.
- i_run  in  1  run command level.
- i_ready  in  1  ready command level.
- i_op_off  in  1  op-off command level.
- i_intl_clr  in  1  interlock/fault clear level.
- i_intl  in  1  OR of all interlocks (analog, external, OC).
- i_dc_ok  in  1  DC-link precharged comparator.
- i_mc_fb  in  1  main contactor auxiliary contact (1 = closed).
- o_pwm_en  out  1  PWM enable.
- o_mc  out  3  [0] precharge relay, [1] main contactor, [2] discharge relay.
- o_mps_fsm_m  out  3  top state.
- o_op_on_fsm  out  4  op-on step.
- o_op_off_fsm  out  4  op-off step.
- o_on_state_fail_buf  out  4  latched failure code.

## Operation
- All command inputs are rising-edge detected against a registered copy. A level held high issues exactly one command.
- Top states (o_mps_fsm_m): 0 IDLE, 1 OP_ON, 2 READY, 3 RUN, 4 OP_OFF, 5 FAULT. Codes 6 and 7 are unused and recover to FAULT.
- Accepted commands, one per cycle. Priority: intl > op_off > op_on > ready > run.
  - op_on: accepted in IDLE only; goes to OP_ON.
  - run: accepted in READY only; goes to RUN.
  - ready: accepted in RUN only; goes to READY.
  - op_off: accepted in READY or RUN; goes to OP_OFF.
  - All other command/state combinations are ignored.
- OP_ON steps (o_op_on_fsm):
  - 0 idle.
  - 1 PRECHG: o_mc[0]=1, counter cleared.
  - 2 PRECHG_WAIT: count PRECHG_CNT cycles, then sample i_dc_ok. If 0, fail code 1.
  - 3 MC_CLOSE: o_mc[1]=1. Wait for i_mc_fb=1. If not seen within FB_TIMEOUT cycles, fail code 2.
  - 4 PRECHG_OPEN: o_mc[0]=0.
  - 5 DONE: top goes to READY, step returns to 0.
- READY: o_mc=3'b010, o_pwm_en=0.
- RUN: o_mc=3'b010, o_pwm_en=1.
- READY and RUN monitor feedback: if i_mc_fb=0 for 1 cycle, fail code 4.
- OP_OFF steps (o_op_off_fsm):
  - 0 idle.
  - 1 PWM_OFF: o_pwm_en=0; wait PWM_OFF_CNT cycles.
  - 2 MC_OPEN: o_mc[1]=0. Wait for i_mc_fb=0 within FB_TIMEOUT, else fail code 3.
  - 3 DISCHARGE (see Configuration).
  - 4 DONE: top goes to IDLE.
- Failure or i_intl=1 in any state except FAULT:
  - Top goes to FAULT; both step registers go to 0.
  - o_pwm_en=0, o_mc[1:0]=0.
  - o_on_state_fail_buf latches the code, or 8 if the cause is i_intl. A nonzero buffer is never overwritten until cleared.
- FAULT exits only on an i_intl_clr edge while i_intl=0: fail buffer clears to 0 and top goes to IDLE. The clear edge is ignored while i_intl=1.

## Timing
- Reset values: o_pwm_en=0, o_mc=0, o_mps_fsm_m=0, o_op_on_fsm=0, o_op_off_fsm=0, o_on_state_fail_buf=0. Edge-detect registers reset to 0.
- All outputs are registered. A command edge on cycle N gives the new state and outputs at cycle N+1.
- i_intl high on cycle N gives o_pwm_en=0 and o_mc[1:0]=0 at N+1.
- Wait counters clear on step entry. A step with count C exits on the cycle after the counter reaches C-1, so the dwell is exactly C cycles in that step.
- Reset mid-sequence returns everything to reset values on the next edge, with relays opened immediately.
- An op_off edge during OP_ON is ignored; software must wait for READY. Interlocks still abort OP_ON.

## Configuration
- MPS_DISCHARGE_EN defined:
  - OP_OFF step 3 drives o_mc[2]=1 for DISCHG_CNT cycles, then goes to DONE.
  - FAULT also holds o_mc[2]=1 until it is cleared.
- MPS_DISCHARGE_EN undefined:
  - Step 3 is skipped; MC_OPEN goes directly to DONE.
  - o_mc[2] is tied to 0.

## Test plan
- Nominal on, PRECHG_CNT=10, i_dc_ok=1, i_mc_fb rises 3 cycles after o_mc[1] -> o_mc steps 001 -> 011 -> 010; o_mps_fsm_m=2; fail buffer 0.
- Precharge fault, i_dc_ok=0 at end of PRECHG_WAIT -> o_mps_fsm_m=5, o_on_state_fail_buf=1, o_mc=0.
- Run and stop with MPS_DISCHARGE_EN: READY, run edge -> o_pwm_en=1. Then op_off -> o_pwm_en=0 for 100 cycles before o_mc[1]=0, then o_mc[2]=1 for 2000 cycles, then IDLE.
- i_intl pulse in RUN -> next cycle o_pwm_en=0, o_mc=0, fail buffer=8. i_intl_clr edge with i_intl=1 is ignored; the same edge after i_intl=0 gives IDLE and buffer 0.
- Contactor feedback never arrives, FB_TIMEOUT=20 -> fail code 2 exactly 20 cycles after MC_CLOSE entry. Simultaneous op_on and op_off edges in IDLE -> op_off has priority, is ignored in IDLE, and the state stays 0.
